// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer sharing one UART transmitter among NUM_REQ
// byte requesters. The winning byte is captured, a one-cycle start is issued to
// the TX datapath, and the arbiter holds until the TX reports frame completion.
// A watchdog aborts the wait if no completion ever arrives.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   req         per-requester request level
//   req_data    requester i byte at [i*DATA_W +: DATA_W]
//   grant       one-hot pulse: byte of that requester captured
//   tx_data     byte presented to UART TX, held until next capture
//   tx_start    one-cycle start pulse to UART TX
//   tx_busy     UART TX currently framing (blocks new grants)
//   tx_done     one-cycle pulse from UART TX after stop bit
//   active_id   index of last granted requester
//   busy        high whenever not idle
//   timeout_err one-cycle pulse on watchdog abort
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [ID_W-1:0]           active_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic                timeout_err_q, timeout_err_d;
  logic [WdW-1:0]      wd_q, wd_d;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W-1:0]     idx_t;
  int unsigned         idx;

  // Scan last+1, last+2, ... so the most recent winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_t = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(last_q) + k) % NUM_REQ;
      idx_t = ID_W'(idx);
      if (!found && req[idx_t]) begin
        found = 1'b1;
        win   = idx_t;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = '0;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    active_id_d   = active_id_q;
    timeout_err_d = 1'b0;
    wd_d          = wd_q;
    unique case (state_q)
      StIdle: begin
        if (found && !tx_busy) begin
          tx_data_d   = req_data[32'(win)*DATA_W +: DATA_W];
          active_id_d = win;
          last_d      = win;
          grant_d     = NUM_REQ'(1) << win;
          tx_start_d  = 1'b1;
          state_d     = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // Completion wins over a simultaneous watchdog expiry.
        if (tx_done) begin
          state_d = StIdle;
        end else if (wd_q == WdMax) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      last_q        <= ID_W'(NUM_REQ - 1);
      grant_q       <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      active_id_q   <= '0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      active_id_q   <= active_id_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign active_id   = active_id_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Three instances: a long-timeout one for
// the normal-flow tests, and TIMEOUT=8 / TIMEOUT=4 ones for the watchdog tests.
module tb_uart_tx_arbiter;

  logic clk;
  logic rst;

  logic [3:0]  req_a, req_b, req_c;
  logic [31:0] data_a, data_b, data_c;
  logic        txb_a, txb_b, txb_c;
  logic        done_a, done_b, done_c;
  logic [3:0]  grant_a, grant_b, grant_c;
  logic [7:0]  txd_a, txd_b, txd_c;
  logic        st_a, st_b, st_c;
  logic [1:0]  id_a, id_b, id_c;
  logic        busy_a, busy_b, busy_c;
  logic        err_a, err_b, err_c;

  int vectors;
  int errors;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_W(2), .TIMEOUT(200000)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_data(data_a), .grant(grant_a),
    .tx_data(txd_a), .tx_start(st_a), .tx_busy(txb_a), .tx_done(done_a),
    .active_id(id_a), .busy(busy_a), .timeout_err(err_a)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_W(2), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_data(data_b), .grant(grant_b),
    .tx_data(txd_b), .tx_start(st_b), .tx_busy(txb_b), .tx_done(done_b),
    .active_id(id_b), .busy(busy_b), .timeout_err(err_b)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .ID_W(2), .TIMEOUT(4)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .req_data(data_c), .grant(grant_c),
    .tx_data(txd_c), .tx_start(st_c), .tx_busy(txb_c), .tx_done(done_c),
    .active_id(id_c), .busy(busy_c), .timeout_err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    data_a = '0; data_b = '0; data_c = '0;
    txb_a = 1'b0; txb_b = 1'b0; txb_c = 1'b0;
    done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
    #2;
    do_reset();

    // Reset state
    check("rst_grant", 32'(grant_a), 32'h0);
    check("rst_txdata", 32'(txd_a), 32'h0);
    check("rst_start", 32'(st_a), 32'h0);
    check("rst_id", 32'(id_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_err", 32'(err_a), 32'h0);

    // 1: single request
    req_a  = 4'b0001;
    data_a = 32'h0000_0055;
    tick();
    check("t1_grant", 32'(grant_a), 32'h1);
    check("t1_start", 32'(st_a), 32'h1);
    check("t1_txdata", 32'(txd_a), 32'h55);
    check("t1_id", 32'(id_a), 32'h0);
    check("t1_busy", 32'(busy_a), 32'h1);
    req_a = '0;
    tick();
    check("t1_grant_clr", 32'(grant_a), 32'h0);
    check("t1_start_clr", 32'(st_a), 32'h0);
    check("t1_txdata_hold", 32'(txd_a), 32'h55);
    repeat (8) tick();
    check("t1_busy_wait", 32'(busy_a), 32'h1);
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check("t1_idle", 32'(busy_a), 32'h0);
    check("t1_noerr", 32'(err_a), 32'h0);

    // 2: all requesting, round-robin order 0,1,2,3,0
    do_reset();
    req_a  = 4'b1111;
    data_a = 32'hA3A2_A1A0;
    for (int f = 0; f < 5; f++) begin
      tick();
      check($sformatf("t2_grant%0d", f), 32'(grant_a), 32'h1 << (f % 4));
      check($sformatf("t2_txdata%0d", f), 32'(txd_a), 32'hA0 + 32'(f % 4));
      check($sformatf("t2_id%0d", f), 32'(id_a), 32'(f % 4));
      tick();
      check($sformatf("t2_start_clr%0d", f), 32'(st_a), 32'h0);
      repeat (3) tick();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
      check($sformatf("t2_gap_busy%0d", f), 32'(busy_a), 32'h0);
      check($sformatf("t2_gap_grant%0d", f), 32'(grant_a), 32'h0);
    end
    req_a = '0;

    // 3: tx_busy blocks grants
    do_reset();
    txb_a  = 1'b1;
    req_a  = 4'b0010;
    data_a = 32'h0000_7700;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_nogrant%0d", i), 32'(grant_a), 32'h0);
      check($sformatf("t3_idle%0d", i), 32'(busy_a), 32'h0);
    end
    txb_a = 1'b0;
    tick();
    check("t3_grant", 32'(grant_a), 32'h2);
    check("t3_id", 32'(id_a), 32'h1);
    check("t3_txdata", 32'(txd_a), 32'h77);
    req_a = '0;
    tick();
    tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    check("t3_done_idle", 32'(busy_a), 32'h0);

    // 4: watchdog timeout with TIMEOUT=8
    do_reset();
    req_b  = 4'b0001;
    data_b = 32'h0000_003C;
    tick();
    check("t4_grant", 32'(grant_b), 32'h1);
    req_b = '0;
    tick();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t4_wait_busy%0d", i), 32'(busy_b), 32'h1);
      check($sformatf("t4_wait_err%0d", i), 32'(err_b), 32'h0);
      tick();
    end
    check("t4_wait_busy7", 32'(busy_b), 32'h1);
    tick();
    check("t4_abort_idle", 32'(busy_b), 32'h0);
    check("t4_err_pulse", 32'(err_b), 32'h1);
    req_b  = 4'b0010;
    data_b = 32'h0000_4400;
    tick();
    check("t4_err_clr", 32'(err_b), 32'h0);
    check("t4_regrant", 32'(grant_b), 32'h2);
    check("t4_regrant_data", 32'(txd_b), 32'h44);
    req_b = '0;

    // 5: reset mid-frame, pointer returns to NUM_REQ-1
    do_reset();
    req_a  = 4'b0100;
    data_a = 32'h0022_1100;
    tick();
    check("t5_grant", 32'(grant_a), 32'h4);
    check("t5_id", 32'(id_a), 32'h2);
    req_a = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy_a), 32'h0);
    check("t5_rst_grant", 32'(grant_a), 32'h0);
    check("t5_rst_start", 32'(st_a), 32'h0);
    check("t5_rst_txdata", 32'(txd_a), 32'h0);
    check("t5_rst_id", 32'(id_a), 32'h0);
    check("t5_rst_err", 32'(err_a), 32'h0);
    req_a = 4'b0110;
    tick();
    check("t5_hold_grant", 32'(grant_a), 32'h0);
    rst = 1'b1;
    tick();
    check("t5_first_grant", 32'(grant_a), 32'h2);
    check("t5_first_id", 32'(id_a), 32'h1);
    check("t5_first_data", 32'(txd_a), 32'h11);
    req_a = '0;

    // 6: tx_done coincident with watchdog expiry (TIMEOUT=4)
    do_reset();
    req_c  = 4'b0001;
    data_c = 32'h0000_005A;
    tick();
    check("t6_grant", 32'(grant_c), 32'h1);
    req_c = '0;
    tick();
    repeat (3) tick();
    check("t6_still_wait", 32'(busy_c), 32'h1);
    done_c = 1'b1;
    tick();
    done_c = 1'b0;
    check("t6_idle", 32'(busy_c), 32'h0);
    check("t6_noerr", 32'(err_c), 32'h0);
    tick();
    check("t6_noerr_late", 32'(err_c), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
